// File: rtl/sc_acc_pkg.sv
// Shared types and default widths for the stochastic-computing window accumulator.
package sc_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;

  localparam int DEF_IWID = 4;
  localparam int DEF_CWID = 8;

endpackage

// File: rtl/sc_window_counter.sv
// Window sample counter: latches the window length at load and flags the final valid sample.
module sc_window_counter #(
  parameter int CWID = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clr,
  input  logic            inc,
  input  logic [CWID-1:0] len,
  output logic            last
);

  logic [CWID-1:0] cnt_q;
  logic [CWID-1:0] len_q;

  // Length is captured only at load so mid-window changes on len are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (inc) begin
      cnt_q <= cnt_q + CWID'(1);
    end
  end

  assign last = inc && (cnt_q == len_q);

endmodule

// File: rtl/sc_window_accumulator.sv
// Accumulates per-cycle adder-tree column sums over a programmable window and
// hands the binary total downstream with a valid/ready handshake.
module sc_window_accumulator
  import sc_acc_pkg::*;
#(
  parameter int IWID = DEF_IWID,
  parameter int CWID = DEF_CWID,
  parameter int OWID = IWID + CWID
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic            iClear,
  input  logic [CWID-1:0] iLen,
  input  logic            iValid,
  input  logic [IWID-1:0] iData,
  input  logic            iReady,
  output logic [OWID-1:0] oData,
  output logic            oValid,
  output logic            oBusy
);

  acc_state_t      state, nxt;
  logic [OWID-1:0] acc;
  logic [OWID-1:0] sum;
  logic            load, clr, inc, last, accept;

  sc_window_counter #(.CWID(CWID)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .clr   (clr),
    .inc   (inc),
    .len   (iLen),
    .last  (last)
  );

  assign sum   = acc + OWID'(iData);
  assign oBusy = (state == ACC);

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    clr    = 1'b0;
    inc    = 1'b0;
    accept = 1'b0;
    if (iClear) begin
      nxt = IDLE;
      clr = 1'b1;
    end else begin
      case (state)
        IDLE: if (iStart) begin
          load = 1'b1;
          nxt  = ACC;
        end
        ACC: if (iValid) begin
          inc = 1'b1;
          if (last) nxt = DONE;
        end
        DONE: if (iReady) begin
          accept = 1'b1;
          load   = iStart;
          nxt    = iStart ? ACC : IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          acc <= '0;
    else if (clr | load) acc <= '0;
    else if (inc)        acc <= sum;
  end

  // oData is only touched on window completion; clear and accept leave it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oData  <= '0;
      oValid <= 1'b0;
    end else if (clr) begin
      oValid <= 1'b0;
    end else if (inc && last) begin
      oData  <= sum;
      oValid <= 1'b1;
    end else if (accept) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_window_accumulator.sv
// Scenario bench for sc_window_accumulator with a queue scoreboard of expected totals.
module tb_sc_window_accumulator;

  localparam int IWID = 4;
  localparam int CWID = 8;
  localparam int OWID = IWID + CWID;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iStart, iClear, iValid, iReady;
  logic [CWID-1:0] iLen;
  logic [IWID-1:0] iData;
  logic [OWID-1:0] oData;
  logic            oValid, oBusy;

  int tests = 0;
  int fails = 0;
  logic [OWID-1:0] exp_q[$];
  logic [OWID-1:0] exp_v;

  sc_window_accumulator #(.IWID(IWID), .CWID(CWID), .OWID(OWID)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iStart (iStart),
    .iClear (iClear),
    .iLen   (iLen),
    .iValid (iValid),
    .iData  (iData),
    .iReady (iReady),
    .oData  (oData),
    .oValid (oValid),
    .oBusy  (oBusy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic v, input int d);
    iValid = v;
    iData  = IWID'(d);
    tick();
    iValid = 1'b0;
  endtask

  task automatic start(input int len);
    iStart = 1'b1;
    iLen   = CWID'(len);
    tick();
    iStart = 1'b0;
  endtask

  task automatic accept();
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  task automatic wait_ovalid(output bit seen);
    int n;
    seen = 1'b0;
    n = 0;
    while (!oValid && n < 600) begin
      tick();
      n++;
    end
    seen = oValid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iStart = 0; iClear = 0; iValid = 0; iReady = 0; iLen = '0; iData = '0;
    #3;
    tests++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oData !== '0) begin
      fails++;
      $display("FAIL reset_state: oValid=%b oBusy=%b oData=%0d, want 0/0/0", oValid, oBusy, oData);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_idle: oBusy=%b want 0", oBusy); end
  endtask

  task automatic test_basic();
    int d[4] = '{5, 7, 0, 15};
    int s = 0;
    start(3);
    tests++;
    if (oBusy !== 1'b1) begin fails++; $display("FAIL basic_busy: oBusy=%b want 1", oBusy); end
    foreach (d[i]) s += d[i];
    exp_q.push_back(OWID'(s));
    for (int i = 0; i < 3; i++) sample(1'b1, d[i]);
    tests++;
    if (oValid !== 1'b0) begin fails++; $display("FAIL basic_early: oValid=%b want 0", oValid); end
    sample(1'b1, d[3]);
    exp_v = exp_q.pop_front();
    tests++;
    if (oValid !== 1'b1 || oData !== exp_v) begin
      fails++;
      $display("FAIL basic_result: oValid=%b oData=%0d, want 1/%0d", oValid, oData, exp_v);
    end
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (oValid !== 1'b1 || oData !== exp_v || oBusy !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: oValid=%b oData=%0d oBusy=%b, want 1/%0d/0", oValid, oData, oBusy, exp_v);
    end
    accept();
    tests++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oData !== exp_v) begin
      fails++;
      $display("FAIL basic_accept: oValid=%b oBusy=%b oData=%0d, want 0/0/%0d", oValid, oBusy, oData, exp_v);
    end
  endtask

  task automatic test_stall();
    logic v[7] = '{1, 0, 0, 1, 1, 0, 1};
    int s = 0;
    bit seen;
    start(3);
    iLen = '0;  // changing iLen mid-window must not shorten the window
    foreach (v[i]) if (v[i]) s += 2;
    exp_q.push_back(OWID'(s));
    for (int i = 0; i < 6; i++) sample(v[i], v[i] ? 2 : 9);
    tests++;
    if (oValid !== 1'b0 || oBusy !== 1'b1) begin
      fails++;
      $display("FAIL stall_midwin: oValid=%b oBusy=%b, want 0/1", oValid, oBusy);
    end
    sample(v[6], 2);
    wait_ovalid(seen);
    exp_v = exp_q.pop_front();
    tests++;
    if (!seen || oData !== exp_v) begin
      fails++;
      $display("FAIL stall_result: seen=%b oData=%0d, want 1/%0d", seen, oData, exp_v);
    end
    accept();
  endtask

  task automatic test_full_window();
    bit seen;
    start(255);
    exp_q.push_back(OWID'(15 * 256));
    for (int i = 0; i < 256; i++) sample(1'b1, 15);
    wait_ovalid(seen);
    exp_v = exp_q.pop_front();
    tests++;
    if (!seen || oData !== exp_v) begin
      fails++;
      $display("FAIL full_window: seen=%b oData=%0d, want 1/%0d", seen, oData, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    // Entered in DONE holding the full-window total.
    sample(1'b1, 15);
    tests++;
    if (oValid !== 1'b1 || oData !== exp_v) begin
      fails++;
      $display("FAIL done_drop: oValid=%b oData=%0d, want 1/%0d", oValid, oData, exp_v);
    end
    iReady = 1'b1; iStart = 1'b1; iLen = '0;
    tick();
    iReady = 1'b0; iStart = 1'b0;
    tests++;
    if (oValid !== 1'b0 || oBusy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: oValid=%b oBusy=%b, want 0/1", oValid, oBusy);
    end
    exp_q.push_back(OWID'(9));
    sample(1'b1, 9);
    exp_v = exp_q.pop_front();
    tests++;
    if (oValid !== 1'b1 || oData !== exp_v) begin
      fails++;
      $display("FAIL b2b_result: oValid=%b oData=%0d, want 1/%0d", oValid, oData, exp_v);
    end
    accept();
  endtask

  task automatic test_clear();
    bit seen;
    logic [OWID-1:0] prev;
    prev = exp_v;
    start(3);
    sample(1'b1, 6);
    sample(1'b1, 6);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    tests++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || oData !== prev) begin
      fails++;
      $display("FAIL clear_abort: oBusy=%b oValid=%b oData=%0d, want 0/0/%0d", oBusy, oValid, oData, prev);
    end
    for (int i = 0; i < 4; i++) sample(1'b1, 5);
    tests++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle_ignore: oValid=%b oBusy=%b, want 0/0", oValid, oBusy);
    end
    start(3);
    exp_q.push_back(OWID'(4));
    for (int i = 0; i < 4; i++) sample(1'b1, 1);
    wait_ovalid(seen);
    exp_v = exp_q.pop_front();
    tests++;
    if (!seen || oData !== exp_v) begin
      fails++;
      $display("FAIL clear_next: seen=%b oData=%0d, want 1/%0d", seen, oData, exp_v);
    end
    // Clear in DONE drops oValid but keeps the delivered value.
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    tests++;
    if (oValid !== 1'b0 || oData !== exp_v) begin
      fails++;
      $display("FAIL clear_done: oValid=%b oData=%0d, want 0/%0d", oValid, oData, exp_v);
    end
  endtask

  task automatic test_reset_mid_acc();
    bit seen;
    start(9);
    sample(1'b1, 10); sample(1'b1, 10); sample(1'b1, 10); sample(1'b1, 7);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oData !== '0) begin
      fails++;
      $display("FAIL async_reset: oValid=%b oBusy=%b oData=%0d, want 0/0/0", oValid, oBusy, oData);
    end
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) sample(1'b1, 3);
    tests++;
    if (oBusy !== 1'b0 || oValid !== 1'b0) begin
      fails++;
      $display("FAIL reset_to_idle: oBusy=%b oValid=%b, want 0/0", oBusy, oValid);
    end
    start(0);
    exp_q.push_back(OWID'(3));
    sample(1'b1, 3);
    wait_ovalid(seen);
    exp_v = exp_q.pop_front();
    tests++;
    if (!seen || oData !== exp_v) begin
      fails++;
      $display("FAIL reset_fresh_acc: seen=%b oData=%0d, want 1/%0d", seen, oData, exp_v);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full_window();
    test_back_to_back();
    test_clear();
    test_reset_mid_acc();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
